// File: rtl/matrix_pkg.sv
// Shared state encoding and default memory map for the matrix multiplier and its
// stream loader, so both sides of the RAM port mux agree on one layout.
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_UNLOAD,
        ST_ERR
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DIM    = 4;
    localparam int DEF_A_BASE = 0;
    localparam int DEF_B_BASE = 16;
    localparam int DEF_C_BASE = 32;

    // True when a region of 'words' entries starting at 'base' fits in the address space.
    function automatic bit region_fits(input int base, input int words, input int addr_w);
        return (longint'(base) + longint'(words) - 1) <= ((longint'(1) << addr_w) - 1);
    endfunction

endpackage

// File: rtl/matrix_skid_buf.sv
// Two-entry result buffer fed by a synchronous-read RAM; tracks the read in flight
// so a new read is only issued when its data is guaranteed a free slot.
module matrix_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_issue_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              can_issue_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              inflight_q;
    logic              push;
    logic              pop;
    logic [1:0]        committed;

    assign push        = inflight_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign pop         = out_valid_o && out_ready_i;
    // Counting this cycle's pop as already gone keeps one word per cycle flowing.
    assign committed   = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign can_issue_o = (committed < 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rd_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_q + {1'b0, push} - {1'b0, pop};
            inflight_q <= rd_issue_i;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Streams A/B into the operand RAM, kicks the multiplier, then streams C back out.
// Optional build macro MATLD_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC cycles.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | accepting 2*N2 words, writing A then B
//   KICK   | one-cycle mm_start, RAM handed to multiplier
//   WAIT   | multiplier owns RAM until done/err
//   UNLOAD | reading C through skid buffer to the output stream
//   ERR    | one cycle flagging the error, back to IDLE
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DIM         = DEF_DIM,
    parameter int A_BASE      = DEF_A_BASE,
    parameter int B_BASE      = DEF_B_BASE,
    parameter int C_BASE      = DEF_C_BASE,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic              ram_own,
    output logic              mm_start,
    input  logic              mm_done,
    input  logic              mm_err,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int N2   = DIM * DIM;
    localparam int LD_W = $clog2(2 * N2) + 1;
    localparam int RD_W = $clog2(N2) + 1;

    if (!region_fits(A_BASE, N2, ADDR_W) || !region_fits(B_BASE, N2, ADDR_W) ||
        !region_fits(C_BASE, N2, ADDR_W)) begin : g_region_chk
        $error("matrix_stream_loader: operand region exceeds RAM address space");
    end

    state_e            state_q, state_d;
    logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [RD_W-1:0]   out_cnt_q, out_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              rd_issue;
    logic              can_issue;
    logic              to_expired;

    matrix_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .rd_issue_i  (rd_issue),
        .rd_data_i   (ram_r_data),
        .can_issue_o (can_issue),
        .out_valid_o (m_valid),
        .out_data_o  (m_data),
        .out_ready_i (m_ready)
    );

    assign m_last     = m_valid && (out_cnt_q == RD_W'(N2 - 1));
    assign ram_w_data = s_data;
    assign err        = err_q;
    assign done       = done_q;

`ifdef MATLD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == ST_KICK) begin
            to_cnt_d = TO_W'(TIMEOUT_CYC - 1);
        end else if (state_q == ST_WAIT && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) to_cnt_q <= '0;
        else      to_cnt_q <= to_cnt_d;
    end

    assign to_expired = (state_q == ST_WAIT) && (to_cnt_q == '0);
`else
    assign to_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        s_ready   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_own   = 1'b1;
        mm_start  = 1'b0;
        rd_issue  = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    err_d     = 1'b0;
                    ld_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (ld_cnt_q < LD_W'(N2)) ram_addr = ADDR_W'(A_BASE) + ADDR_W'(ld_cnt_q);
                else ram_addr = ADDR_W'(B_BASE) + ADDR_W'(ld_cnt_q) - ADDR_W'(N2);
                if (s_valid) begin
                    ram_we   = 1'b1;
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == LD_W'(2 * N2 - 1)) state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                mm_start = 1'b1;
                ram_own  = 1'b0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                ram_own = 1'b0;
                if (mm_err || to_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (mm_done) begin
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                ram_addr = ADDR_W'(C_BASE) + ADDR_W'(rd_cnt_q);
                if (rd_cnt_q < RD_W'(N2) && can_issue) begin
                    rd_issue = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (m_valid && m_ready) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == RD_W'(N2 - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ld_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader: job table plus reset and watchdog
// sequences, with RAM and multiplier behavioural models and output scoreboards.
module tb_matrix_stream_loader;

    localparam int TB_A_BASE = 0;
    localparam int TB_B_BASE = 16;
    localparam int TB_C_BASE = 32;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [7:0] s_data = 8'h0, ram_r_data = 8'h0;
    logic       mm_done = 1'b0, mm_err = 1'b0;
    logic       s_ready, m_valid, m_last, ram_we, ram_own, mm_start, busy, done, err;
    logic [7:0] m_data, ram_w_data;
    logic [8:0] ram_addr;

    matrix_stream_loader #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .ram_addr(ram_addr), .ram_we(ram_we), .ram_w_data(ram_w_data),
        .ram_r_data(ram_r_data), .ram_own(ram_own), .mm_start(mm_start),
        .mm_done(mm_done), .mm_err(mm_err), .busy(busy), .done(done), .err(err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed { logic [8:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [7:0] data; logic last; } out_t;
    typedef struct { int a_kind; int b_kind; bit gaps; int rdy_mode; int mm_mode; bit exp_err; } job_t;

    logic [7:0] ram [512];
    int         a_m [16];
    int         b_m [16];
    wr_t        wr_q [$];
    out_t       c_q [$];
    wr_t        mon_w;
    out_t       mon_o;
    int         n_vec = 0, n_err = 0;
    int         n_writes = 0, n_out = 0, n_mmstart = 0;
    int         rdy_mode = 0, mm_mode = 0, mm_cnt = 0, rdy_cyc = 0;
    logic [8:0] cap_addr = '0;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Negedge monitor: write scoreboard, kick ordering, output scoreboard, stall stability, RAM writes.
    always @(negedge clk) begin
        if (rst) begin
            if (ram_we || (s_valid && s_ready)) begin
                check("we_is_handshake", ram_we, s_valid && s_ready);
                if (ram_we) begin
                    n_writes++;
                    check("write_expected", wr_q.size() > 0, 1);
                    if (wr_q.size() > 0) begin
                        mon_w = wr_q.pop_front();
                        check("write_addr_data", {ram_addr, ram_w_data}, mon_w);
                    end
                end
            end
            if (mm_start) begin
                n_mmstart++;
                check("kick_after_32_writes", n_writes, 32);
                mm_cnt = (mm_mode == 2) ? 0 : 10;
            end
            if (stall_prev && m_valid) check("stall_stable", {m_data, m_last}, {stall_data, stall_last});
            if (m_valid && m_ready) begin
                n_out++;
                check("output_expected", c_q.size() > 0, 1);
                if (c_q.size() > 0) begin
                    mon_o = c_q.pop_front();
                    check("output_word", {m_data, m_last}, mon_o);
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            cap_addr   = ram_addr;
            if (ram_we) ram[ram_addr] = ram_w_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 ram_r_data = ram[cap_addr];
    end

    // Multiplier model: computes C from what the loader actually wrote into RAM.
    initial forever begin
        tick();
        mm_done = 1'b0;
        mm_err  = 1'b0;
        if (mm_cnt > 0) begin
            mm_cnt--;
            if (mm_cnt == 0) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        int s;
                        s = 0;
                        for (int k = 0; k < 4; k++)
                            s += int'(ram[TB_A_BASE + i*4 + k]) * int'(ram[TB_B_BASE + k*4 + j]);
                        ram[TB_C_BASE + i*4 + j] = s[7:0];
                    end
                end
                mm_done = 1'b1;
                if (mm_mode == 1) mm_err = 1'b1;
            end
        end
    end

    initial forever begin
        tick();
        rdy_cyc++;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (rdy_cyc % 3 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic load_mats(input int a_kind, input int b_kind, input bit gaps);
        int d, addr, guard;
        for (int i = 0; i < 16; i++) begin
            a_m[i] = (a_kind == 0) ? ((i / 4 == i % 4) ? 1 : 0) : int'($urandom_range(0, 255));
            b_m[i] = (b_kind == 0) ? (i + 1) : int'($urandom_range(0, 255));
        end
        for (int beat = 0; beat < 32; beat++) begin
            d    = (beat < 16) ? a_m[beat] : b_m[beat - 16];
            addr = (beat < 16) ? (TB_A_BASE + beat) : (TB_B_BASE + beat - 16);
            if (gaps && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                tick();
            end
            wr_q.push_back({9'(addr), 8'(d)});
            s_valid = 1'b1;
            s_data  = 8'(d);
            guard   = 0;
            while (!s_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!s_ready) check("s_ready_in_load", s_ready, 1);
            tick();
        end
        s_valid = 1'b0;
        s_data  = 8'h0;
    endtask

    task automatic push_expected_c();
        int s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += a_m[i*4 + k] * b_m[k*4 + j];
                c_q.push_back({8'(s), (i == 3 && j == 3)});
            end
        end
    endtask

    task automatic start_job(input int rmode, input int mmode);
        rdy_mode  = rmode;
        mm_mode   = mmode;
        n_writes  = 0;
        n_out     = 0;
        n_mmstart = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", err, 0);
    endtask

    task automatic run_job(input job_t j);
        bit got_done, got_err;
        start_job(j.rdy_mode, j.mm_mode);
        load_mats(j.a_kind, j.b_kind, j.gaps);
        if (!j.exp_err) push_expected_c();
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int t = 0; t < 2000 && !got_done && !got_err; t++) begin
            tick();
            got_done = done;
            got_err  = err;
        end
        check("done_pulse", got_done, !j.exp_err);
        check("err_flag", got_err, j.exp_err);
        check("busy_at_end", busy, 0);
        check("mm_start_count", n_mmstart, 1);
        check("write_count", n_writes, 32);
        check("out_count", n_out, j.exp_err ? 0 : 16);
        check("out_queue_drained", c_q.size(), 0);
        tick();
        check("done_one_cycle", done, 0);
        check("err_sticky", err, j.exp_err);
        check("idle_after_job", busy, 0);
        c_q.delete();
        wr_q.delete();
    endtask

    // {s_ready,m_valid,m_data,m_last,ram_addr,ram_we,ram_w_data,ram_own,mm_start,busy,done,err}
    function automatic logic [33:0] out_vec();
        return {s_ready, m_valid, m_data, m_last, ram_addr, ram_we, ram_w_data,
                ram_own, mm_start, busy, done, err};
    endfunction

    localparam logic [33:0] RESET_VEC = 34'b0000 | (34'd1 << 4);

    job_t jobs [5];
    int   wait_cyc;

    initial begin
        jobs[0] = '{a_kind: 0, b_kind: 0, gaps: 1'b0, rdy_mode: 0, mm_mode: 0, exp_err: 1'b0};
        jobs[1] = '{a_kind: 1, b_kind: 1, gaps: 1'b0, rdy_mode: 1, mm_mode: 0, exp_err: 1'b0};
        jobs[2] = '{a_kind: 0, b_kind: 1, gaps: 1'b1, rdy_mode: 0, mm_mode: 0, exp_err: 1'b0};
        jobs[3] = '{a_kind: 1, b_kind: 1, gaps: 1'b0, rdy_mode: 0, mm_mode: 1, exp_err: 1'b1};
        jobs[4] = '{a_kind: 1, b_kind: 1, gaps: 1'b1, rdy_mode: 2, mm_mode: 0, exp_err: 1'b0};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", out_vec(), RESET_VEC);
        rst = 1'b1;
        tick();
        check("idle_outputs", out_vec(), RESET_VEC);

        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Async reset after five output beats, then a clean job.
        start_job(0, 0);
        load_mats(0, 0, 1'b0);
        push_expected_c();
        for (int t = 0; t < 500 && n_out < 5; t++) tick();
        check("five_beats_before_reset", n_out >= 5, 1);
        rst    = 1'b0;
        s_data = 8'h0;
        #1;
        check("mid_unload_reset_outputs", out_vec(), RESET_VEC);
        c_q.delete();
        wr_q.delete();
        mm_cnt = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_job(jobs[0]);

        // Multiplier that never answers.
        start_job(0, 2);
        load_mats(1, 1, 1'b0);
        wait_cyc = 0;
        for (int t = 0; t < 400 && !err; t++) begin
            tick();
            if (busy && !ram_own && !mm_start) wait_cyc++;
        end
`ifdef MATLD_TIMEOUT_EN
        check("timeout_wait_cycles", wait_cyc, 64);
        check("timeout_err", err, 1);
        check("timeout_ram_own", ram_own, 1);
        tick();
        check("timeout_idle", busy, 0);
`else
        check("no_timeout_busy", busy, 1);
        check("no_timeout_err", err, 0);
        check("no_timeout_wait_cycles", wait_cyc, 400);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`endif
        wr_q.delete();
        c_q.delete();
        run_job(jobs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
